// File: rtl/posit_adder_vector_checker_if.sv
// Bundle of vector-memory, adder and status/log signals for the posit adder self-test engine.
// The master side is the checker; the slave side is the memory/adder environment.
interface posit_adder_vector_checker_if #(
   parameter int N      = 8,
   parameter int ADDR_W = 16
);
   logic              go;
   logic [ADDR_W-1:0] last_addr;
   logic [N-1:0]      tol;
   logic [ADDR_W-1:0] mem_addr;
   logic [N-1:0]      mem_in1;
   logic [N-1:0]      mem_in2;
   logic [N-1:0]      mem_exp;
   logic [N-1:0]      dut_in1;
   logic [N-1:0]      dut_in2;
   logic              dut_start;
   logic [N-1:0]      dut_result;
   logic              dut_done;
   logic              busy;
   logic              finished;
   logic              pass;
   logic [ADDR_W:0]   err_count;
   logic [N-1:0]      max_diff;
   logic              proto_err;
   logic [ADDR_W-1:0] first_err_addr;
   logic              log_valid;
   logic [ADDR_W-1:0] log_addr;
   logic [N-1:0]      log_result;
   logic [N-1:0]      log_expected;
   logic [N-1:0]      log_diff;
   logic              log_fail;

   modport master (
      input  go, last_addr, tol, mem_in1, mem_in2, mem_exp, dut_result, dut_done,
      output mem_addr, dut_in1, dut_in2, dut_start, busy, finished, pass, err_count,
             max_diff, proto_err, first_err_addr, log_valid, log_addr, log_result,
             log_expected, log_diff, log_fail
   );

   modport slave (
      output go, last_addr, tol, mem_in1, mem_in2, mem_exp, dut_result, dut_done,
      input  mem_addr, dut_in1, dut_in2, dut_start, busy, finished, pass, err_count,
             max_diff, proto_err, first_err_addr, log_valid, log_addr, log_result,
             log_expected, log_diff, log_fail
   );
endinterface

// File: rtl/posit_adder_vector_checker.sv
// Streams vectors from memory into an external posit adder, aligns expected values to the
// adder latency, compares within a tolerance and reports per-vector records and run statistics.
module posit_adder_vector_checker #(
   parameter int N       = 8,
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 16
) (
   input logic aclk,
   input logic areset,
   posit_adder_vector_checker_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

   state_t            state;
   logic [ADDR_W-1:0] last_q;
   logic [N-1:0]      tol_q;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W:0]   outstanding;

   // Stage 0 is loaded together with dut_start, so stage LATENCY lines up with dut_done.
   logic [LATENCY:0]  al_vld;
   logic [N-1:0]      al_exp [0:LATENCY];
   logic [ADDR_W-1:0] al_idx [0:LATENCY];

   logic              tail_vld;
   logic [N-1:0]      tail_exp;
   logic [ADDR_W-1:0] tail_idx;
   logic              nar_mismatch;
   logic [N-1:0]      abs_diff;
   logic [N-1:0]      diff;
   logic              fail;
   logic              issue;

   always_comb begin
      tail_vld     = al_vld[LATENCY];
      tail_exp     = al_exp[LATENCY];
      tail_idx     = al_idx[LATENCY];
      issue        = (state == ISSUE);
      nar_mismatch = (tail_exp == NAR) != (bus.dut_result == NAR);
      abs_diff     = (tail_exp >= bus.dut_result) ? tail_exp - bus.dut_result
                                                  : bus.dut_result - tail_exp;
      diff         = nar_mismatch ? '1 : abs_diff;
      fail         = !bus.dut_done || nar_mismatch || (abs_diff > tol_q);
   end

   // Memory read data arrives one cycle after mem_addr; rd_valid/rd_idx track that read.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state              <= IDLE;
         last_q             <= '0;
         tol_q              <= '0;
         rd_valid           <= 1'b0;
         rd_idx             <= '0;
         outstanding        <= '0;
         al_vld             <= '0;
         for (int i = 0; i <= LATENCY; i++) begin
            al_exp[i] <= '0;
            al_idx[i] <= '0;
         end
         bus.mem_addr       <= '0;
         bus.dut_in1        <= '0;
         bus.dut_in2        <= '0;
         bus.dut_start      <= 1'b0;
         bus.busy           <= 1'b0;
         bus.finished       <= 1'b0;
         bus.pass           <= 1'b0;
         bus.err_count      <= '0;
         bus.max_diff       <= '0;
         bus.proto_err      <= 1'b0;
         bus.first_err_addr <= '0;
         bus.log_valid      <= 1'b0;
         bus.log_addr       <= '0;
         bus.log_result     <= '0;
         bus.log_expected   <= '0;
         bus.log_diff       <= '0;
         bus.log_fail       <= 1'b0;
      end else begin
         rd_valid      <= 1'b0;
         bus.log_valid <= 1'b0;
         bus.dut_start <= rd_valid;
         if (rd_valid) begin
            bus.dut_in1 <= bus.mem_in1;
            bus.dut_in2 <= bus.mem_in2;
         end
         al_vld    <= {al_vld[LATENCY-1:0], rd_valid};
         al_exp[0] <= bus.mem_exp;
         al_idx[0] <= rd_idx;
         for (int i = 1; i <= LATENCY; i++) begin
            al_exp[i] <= al_exp[i-1];
            al_idx[i] <= al_idx[i-1];
         end
         outstanding <= outstanding + (ADDR_W+1)'(issue) - (ADDR_W+1)'(tail_vld);

         if (tail_vld) begin
            bus.log_valid    <= 1'b1;
            bus.log_addr     <= tail_idx;
            bus.log_result   <= bus.dut_result;
            bus.log_expected <= tail_exp;
            bus.log_diff     <= diff;
            bus.log_fail     <= fail;
            if (diff > bus.max_diff) bus.max_diff <= diff;
            if (fail) begin
               bus.err_count <= bus.err_count + (ADDR_W+1)'(1);
               if (bus.err_count == '0) bus.first_err_addr <= tail_idx;
            end
            if (!bus.dut_done) bus.proto_err <= 1'b1;
         end else if (bus.dut_done) begin
            bus.proto_err <= 1'b1;
         end

         // The address stops at last_addr rather than incrementing, so a full-space run never wraps.
         case (state)
            IDLE, DONE: begin
               if (bus.go) begin
                  state              <= ISSUE;
                  last_q             <= bus.last_addr;
                  tol_q              <= bus.tol;
                  bus.mem_addr       <= '0;
                  bus.busy           <= 1'b1;
                  bus.finished       <= 1'b0;
                  bus.pass           <= 1'b0;
                  bus.err_count      <= '0;
                  bus.max_diff       <= '0;
                  bus.proto_err      <= 1'b0;
                  bus.first_err_addr <= '0;
               end
            end
            ISSUE: begin
               rd_valid <= 1'b1;
               rd_idx   <= bus.mem_addr;
               if (bus.mem_addr == last_q) state <= DRAIN;
               else bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            end
            DRAIN: begin
               if (outstanding == '0) begin
                  state        <= DONE;
                  bus.busy     <= 1'b0;
                  bus.finished <= 1'b1;
                  bus.pass     <= (bus.err_count == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
